// File: rtl/seq_pkg.sv
// Shared constants and FSM encoding for the beat sequencer.
package seq_pkg;

  localparam int unsigned NOTE_W         = 5;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  localparam int unsigned STEPS_DEFAULT  = 16;
  localparam int unsigned GATE_W_DEFAULT = 24;

  // IDLE: paused, gate low. GATE: note sounding. WAIT: gate done, awaiting next tick.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGate = 2'd1,
    StWait = 2'd2
  } seq_state_e;

endpackage

// File: rtl/gate_timer.sv
// Gate-length down counter: load, decrement and last-cycle flag.
module gate_timer #(
  parameter int unsigned GATE_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [GATE_W-1:0] load_val,
  input  logic              dec,
  output logic              expire
);

  logic [GATE_W-1:0] count_q, count_d;

  // Next count: clear wins, then load (zero length treated as one), then decrement.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val == '0) ? GATE_W'(1) : load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - GATE_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High during the final gate cycle; the FSM drops the gate on the following edge.
  assign expire = (count_q == GATE_W'(1));

endmodule

// File: rtl/beat_sequencer.sv
// Step sequencer: pattern store, step pointer and gate FSM with registered outputs.
module beat_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned STEPS  = STEPS_DEFAULT,
  parameter int unsigned GATE_W = GATE_W_DEFAULT,
  localparam int unsigned IDX_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat_tick,
  input  logic              play,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [NOTE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  last_step,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic [NOTE_W-1:0] note_out,
  output logic              gate,
  output logic [IDX_W-1:0]  step_idx,
  output logic              step_pulse
);

  logic [NOTE_W-1:0] pat_q [STEPS];
  logic [NOTE_W-1:0] pat_d [STEPS];

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pulse_q, pulse_d;
  logic              gate_q, gate_d;

  logic              timer_load, timer_clear, timer_expire;
  logic [NOTE_W-1:0] cur_note;
  logic [IDX_W-1:0]  ptr_next;

  // Pattern write; reads below see pat_q, so a same-cycle write is not visible yet.
  always_comb begin
    pat_d = pat_q;
    if (wr_en) begin
      pat_d[wr_addr] = wr_data;
    end
  end

  // Pattern registers, cleared to rests on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STEPS; i++) begin
        pat_q[i] <= NOTE_REST;
      end
    end else begin
      pat_q <= pat_d;
    end
  end

  assign cur_note = pat_q[ptr_q];
  // >= also wraps when last_step was lowered below the current pointer.
  assign ptr_next = (ptr_q >= last_step) ? '0 : ptr_q + IDX_W'(1);

  // Next-state and output decode; pause dominates, then tick, then gate expiry.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    note_d      = note_q;
    idx_d       = idx_q;
    pulse_d     = 1'b0;
    gate_d      = gate_q;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    if (!play) begin
      state_d     = StIdle;
      gate_d      = 1'b0;
      timer_clear = 1'b1;
    end else if (beat_tick) begin
      note_d  = cur_note;
      idx_d   = ptr_q;
      pulse_d = 1'b1;
      ptr_d   = ptr_next;
      if (cur_note != NOTE_REST) begin
        state_d    = StGate;
        gate_d     = 1'b1;
        timer_load = 1'b1;
      end else begin
        state_d     = StWait;
        gate_d      = 1'b0;
        timer_clear = 1'b1;
      end
    end else if ((state_q == StGate) && timer_expire) begin
      state_d = StWait;
      gate_d  = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      note_q  <= NOTE_REST;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      note_q  <= note_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      gate_q  <= gate_d;
    end
  end

  gate_timer #(
    .GATE_W (GATE_W)
  ) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .load     (timer_load),
    .load_val (gate_cycles),
    .dec      (state_q == StGate),
    .expire   (timer_expire)
  );

  assign note_out   = note_q;
  assign gate       = gate_q;
  assign step_idx   = idx_q;
  assign step_pulse = pulse_q;

endmodule
